// File: rtl/checkpoint_recovery_if.sv
// ---------------------------------------------------------------------------
// checkpoint_recovery_if
// Bundles the signals between the branch units, the checkpointer and the
// recovery controller.
//
// Handshake: there is no backpressure on this bus. A resolution lane carries
// a result in every cycle its res_valid bit is high. validate/validated_id
// are qualified by validate[i]. recall_checkpoint and restore_en are
// single-cycle strobes. flush_frontend and recovery_stall are levels.
//
// Modports:
//   master - branch units / checkpointer side (drives the res_* lanes and
//            checkpoint_back, observes the recovery outputs)
//   slave  - recovery controller side
// ---------------------------------------------------------------------------
interface checkpoint_recovery_if #(
    parameter int NUM_CHECKPOINTS = 8,
    parameter int NUM_RESOLVE     = 2
);
    localparam int CPW = $clog2(NUM_CHECKPOINTS);

    logic [NUM_RESOLVE-1:0]          res_valid;
    logic [NUM_RESOLVE-1:0][CPW-1:0] res_id;
    logic [NUM_RESOLVE-1:0]          res_mispredict;
    logic [CPW-1:0]                  checkpoint_back;

    logic [NUM_RESOLVE-1:0]          validate;
    logic [NUM_RESOLVE-1:0][CPW-1:0] validated_id;
    logic                            recall_checkpoint;
    logic [CPW-1:0]                  recall_id;
    logic                            restore_en;
    logic                            flush_frontend;
    logic                            recovery_stall;
    logic                            busy;

    modport master (
        output res_valid, res_id, res_mispredict, checkpoint_back,
        input  validate, validated_id, recall_checkpoint, recall_id,
               restore_en, flush_frontend, recovery_stall, busy
    );

    modport slave (
        input  res_valid, res_id, res_mispredict, checkpoint_back,
        output validate, validated_id, recall_checkpoint, recall_id,
               restore_en, flush_frontend, recovery_stall, busy
    );
endinterface

// File: rtl/checkpoint_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// checkpoint_recovery_ctrl
// Turns branch resolutions into checkpoint validations. It also drives the
// oldest misprediction through a recall -> restore -> flush sequence while
// the frontend is stalled.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   bus          checkpoint_recovery_if.slave (resolution lanes in;
//                validate / recall / restore / flush / stall / busy out)
//   o_dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module checkpoint_recovery_ctrl #(
    parameter int NUM_CHECKPOINTS = 8,
    parameter int NUM_RESOLVE     = 2,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    checkpoint_recovery_if.slave  bus,
    output logic [1:0]            o_dbg_state
);
    localparam int CPW = $clog2(NUM_CHECKPOINTS);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECALL  = 2'd1,
        S_RESTORE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t         r_state,      w_state_nxt;
    logic [CPW-1:0] r_active_id,  w_active_id_nxt;
    logic [CPW-1:0] r_active_age, w_active_age_nxt;
    logic [FCW-1:0] r_flush_cnt,  w_flush_cnt_nxt;

    logic [NUM_RESOLVE-1:0][CPW-1:0] w_lane_age;
    logic                            w_cand_found;
    logic [CPW-1:0]                  w_cand_id;
    logic [CPW-1:0]                  w_cand_age;
    logic                            w_idle;
    logic                            w_preempt;
    logic                            w_keep_all;
    logic [CPW-1:0]                  w_ref_age;

    // Age is the distance from the oldest live checkpoint. It wraps in CPW
    // bits. The strict '<' makes the lowest lane win on an age tie.
    always_comb begin
        w_lane_age   = '0;
        w_cand_found = 1'b0;
        w_cand_id    = '0;
        w_cand_age   = '0;
        for (int i = 0; i < NUM_RESOLVE; i++) begin
            w_lane_age[i] = bus.res_id[i] - bus.checkpoint_back;
            if (bus.res_valid[i] && bus.res_mispredict[i] &&
                (!w_cand_found || (w_lane_age[i] < w_cand_age))) begin
                w_cand_found = 1'b1;
                w_cand_id    = bus.res_id[i];
                w_cand_age   = w_lane_age[i];
            end
        end
    end

    assign w_idle    = (r_state == S_IDLE);
    assign w_preempt = !w_idle && w_cand_found && (w_cand_age < r_active_age);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_active_id  <= '0;
            r_active_age <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_active_id  <= w_active_id_nxt;
            r_active_age <= w_active_age_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_active_id_nxt  = r_active_id;
        w_active_age_nxt = r_active_age;
        w_flush_cnt_nxt  = r_flush_cnt;
        if (w_idle) begin
            if (w_cand_found) begin
                w_state_nxt      = S_RECALL;
                w_active_id_nxt  = w_cand_id;
                w_active_age_nxt = w_cand_age;
            end
        end else if (w_preempt) begin
            // An older misprediction restarts the whole sequence on itself.
            w_state_nxt      = S_RECALL;
            w_active_id_nxt  = w_cand_id;
            w_active_age_nxt = w_cand_age;
        end else begin
            case (r_state)
                S_RECALL:  w_state_nxt = S_RESTORE;
                S_RESTORE: begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = FCW'(FLUSH_CYCLES - 1);
                end
                S_FLUSH: begin
                    if (r_flush_cnt == '0) w_state_nxt = S_IDLE;
                    else w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
                end
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Recovery strobes come only from the state register.
    assign bus.recall_checkpoint = (r_state == S_RECALL);
    assign bus.recall_id         = (r_state == S_RECALL) ? r_active_id : '0;
    assign bus.restore_en        = (r_state == S_RESTORE);
    assign bus.flush_frontend    = (r_state == S_FLUSH);
    assign bus.busy              = !w_idle;
    assign bus.recovery_stall    = !reset && (!w_idle || w_cand_found);
    assign o_dbg_state           = r_state;

    // Anything at or younger than the recovery point is squashed. The
    // recovery point is the new candidate when one is being taken this
    // cycle. Otherwise it is the recovery already in flight.
    assign w_keep_all = w_idle && !w_cand_found;
    assign w_ref_age  = (w_idle || w_preempt) ? w_cand_age : r_active_age;

    always_comb begin
        bus.validate     = '0;
        bus.validated_id = '0;
        if (!reset) begin
            for (int i = 0; i < NUM_RESOLVE; i++) begin
                bus.validate[i]     = bus.res_valid[i] && !bus.res_mispredict[i] &&
                                      (w_keep_all || (w_lane_age[i] < w_ref_age));
                bus.validated_id[i] = bus.res_id[i];
            end
        end
    end
endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
module tb_checkpoint_recovery_ctrl;
  localparam int NC    = 8;
  localparam int NR    = 3;
  localparam int FC    = 2;
  localparam int CPW   = $clog2(NC);
  localparam int TOTAL = FC + 2;   // cycles a recovery keeps the block busy

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  checkpoint_recovery_if #(.NUM_CHECKPOINTS(NC), .NUM_RESOLVE(NR)) bus ();

  checkpoint_recovery_ctrl #(
    .NUM_CHECKPOINTS(NC),
    .NUM_RESOLVE(NR),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec;
  int n_checks;
  int n_fail;

  // ---------------- reference model ----------------
  // A recovery is a countdown of the cycles still to spend busy:
  // TOTAL = recall, TOTAL-1 = restore, FC..1 = flush, 0 = idle.
  int             m_left;
  int             m_aid;
  int             m_aage;
  bit             m_found;
  int             m_best;
  int             m_bid;
  bit             m_pre;
  logic [CPW-1:0] cur_back;

  function automatic int age_of(input int id, input int back);
    return (id - back + NC) % NC;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] mp,
                       input logic [NR-1:0][CPW-1:0] ids, input logic [CPW-1:0] back);
    bus.res_valid       = v;
    bus.res_mispredict  = mp;
    bus.res_id          = ids;
    bus.checkpoint_back = back;
    cur_back            = back;
  endtask

  task automatic idle_in();
    drive('0, '0, '0, cur_back);
  endtask

  task automatic model_check();
    logic [NR-1:0] ev;
    int a;
    int refa;
    m_found = 0; m_best = 0; m_bid = 0;
    for (int i = 0; i < NR; i++) begin
      if (bus.res_valid[i] && bus.res_mispredict[i]) begin
        a = age_of(int'(bus.res_id[i]), int'(bus.checkpoint_back));
        if (!m_found || a < m_best) begin
          m_found = 1; m_best = a; m_bid = int'(bus.res_id[i]);
        end
      end
    end
    m_pre = (m_left > 0) && m_found && (m_best < m_aage);
    refa  = (m_left == 0 || m_pre) ? m_best : m_aage;
    ev = '0;
    for (int i = 0; i < NR; i++) begin
      if (bus.res_valid[i] && !bus.res_mispredict[i]) begin
        if (m_left == 0 && !m_found) ev[i] = 1'b1;
        else ev[i] = (age_of(int'(bus.res_id[i]), int'(bus.checkpoint_back)) < refa);
      end
      if (ev[i]) check($sformatf("validated_id[%0d]", i), 32'(bus.validated_id[i]), 32'(bus.res_id[i]));
    end
    check("validate", 32'(bus.validate), 32'(ev));
    check("busy", 32'(bus.busy), 32'(m_left > 0));
    check("recall_checkpoint", 32'(bus.recall_checkpoint), 32'(m_left == TOTAL));
    check("restore_en", 32'(bus.restore_en), 32'(m_left == TOTAL - 1));
    check("flush_frontend", 32'(bus.flush_frontend), 32'(m_left >= 1 && m_left <= FC));
    check("recovery_stall", 32'(bus.recovery_stall), 32'(m_left > 0 || m_found));
    if (m_left == TOTAL) check("recall_id", 32'(bus.recall_id), 32'(m_aid));
  endtask

  task automatic model_update();
    if ((m_left == 0 && m_found) || m_pre) begin
      m_aid  = m_bid;
      m_aage = m_best;
      m_left = TOTAL;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  // Called at posedge+1 (inputs already driven); returns at next posedge+1.
  task automatic step();
    #3;
    model_check();
    @(posedge clk);
    model_update();
    n_vec++;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_checks = 0; n_fail = 0;
    m_left = 0; m_aid = 0; m_aage = 0; cur_back = '0;
    reset = 1'b1;
    drive('0, '0, '0, '0);
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.recovery_stall), 32'd0);
    check("rst_recall", 32'(bus.recall_checkpoint), 32'd0);
    check("rst_recall_id", 32'(bus.recall_id), 32'd0);
    check("rst_restore", 32'(bus.restore_en), 32'd0);
    check("rst_flush", 32'(bus.flush_frontend), 32'd0);
    check("rst_validate", 32'(bus.validate), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // 1: correct branch while idle validates in the same cycle
    drive(3'b001, 3'b000, {3'd0, 3'd0, 3'd3}, 3'd0);
    #2;
    check("t1_validate0", 32'(bus.validate[0]), 32'd1);
    check("t1_validated_id0", 32'(bus.validated_id[0]), 32'd3);
    check("t1_busy", 32'(bus.busy), 32'd0);
    step();

    // 2: single mispredict, full sequence
    drive(3'b010, 3'b010, {3'd0, 3'd5, 3'd0}, 3'd2);
    #2;
    check("t2_stall_now", 32'(bus.recovery_stall), 32'd1);
    check("t2_busy_now", 32'(bus.busy), 32'd0);
    step();
    idle_in(); #2;
    check("t2_recall", 32'(bus.recall_checkpoint), 32'd1);
    check("t2_recall_id", 32'(bus.recall_id), 32'd5);
    step(); #2;
    check("t2_restore", 32'(bus.restore_en), 32'd1);
    step(); #2;
    check("t2_flush_a", 32'(bus.flush_frontend), 32'd1);
    step(); #2;
    check("t2_flush_b", 32'(bus.flush_frontend), 32'd1);
    step(); #2;
    check("t2_done_busy", 32'(bus.busy), 32'd0);
    check("t2_done_flush", 32'(bus.flush_frontend), 32'd0);
    step();

    // 3: two mispredicts, the older (lane1, age 1) wins
    drive(3'b011, 3'b011, {3'd0, 3'd6, 3'd1}, 3'd5);
    #2;
    check("t3_validate", 32'(bus.validate), 32'd0);
    step();
    idle_in(); #2;
    check("t3_recall_id", 32'(bus.recall_id), 32'd6);
    repeat (TOTAL) step();

    // 4: preemption during FLUSH with squash of younger branches
    drive(3'b001, 3'b001, {3'd0, 3'd0, 3'd4}, 3'd0);
    step();
    idle_in();
    step();
    step();
    drive(3'b111, 3'b001, {3'd3, 3'd1, 3'd2}, 3'd0);
    #2;
    check("t4_in_flush", 32'(bus.flush_frontend), 32'd1);
    check("t4_validate", 32'(bus.validate), 32'b010);
    step();
    idle_in(); #2;
    check("t4_recall", 32'(bus.recall_checkpoint), 32'd1);
    check("t4_recall_id", 32'(bus.recall_id), 32'd2);
    repeat (TOTAL) step();

    // 5: wrap-around ages
    drive(3'b011, 3'b011, {3'd0, 3'd0, 3'd7}, 3'd6);
    step();
    idle_in(); #2;
    check("t5_recall_id", 32'(bus.recall_id), 32'd7);
    repeat (TOTAL) step();

    // 6: asynchronous reset during RESTORE
    drive(3'b001, 3'b001, {3'd0, 3'd0, 3'd3}, 3'd0);
    step();
    idle_in();
    step();
    #2;
    check("t6_restore_before", 32'(bus.restore_en), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_restore_async", 32'(bus.restore_en), 32'd0);
    check("t6_busy_async", 32'(bus.busy), 32'd0);
    check("t6_stall_async", 32'(bus.recovery_stall), 32'd0);
    m_left = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("t6_idle_after", 32'(bus.busy), 32'd0);
    step();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [NR-1:0] v;
      logic [NR-1:0] mp;
      logic [NR-1:0][CPW-1:0] ids;
      logic [CPW-1:0] back;
      back = cur_back;
      if ($urandom_range(0, 7) == 0) back = CPW'($urandom_range(0, NC - 1));
      for (int i = 0; i < NR; i++) begin
        v[i]   = 1'($urandom_range(0, 1));
        mp[i]  = ($urandom_range(0, 5) == 0);
        ids[i] = CPW'($urandom_range(0, NC - 1));
      end
      drive(v, mp, ids, back);
      step();
    end

    idle_in();
    repeat (TOTAL + 1) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/checkpoint_recovery_ctrl.md
Name: checkpoint_recovery_ctrl

Overview:
Sequences branch resolution into the checkpointer. Each cycle it takes up to NUM_RESOLVE branch-resolution results from the execute units. Correct predictions become checkpoint validations. The oldest misprediction is chosen and driven through a multi-cycle recall/restore/flush sequence that stalls the frontend. It sits between the branch units and the checkpointer/rename stage.

Parameters:
NUM_CHECKPOINTS, 8, checkpoint slots; CPW = $clog2(NUM_CHECKPOINTS)
NUM_RESOLVE, 2, branch results accepted per cycle (matches NUM_BRANCHES_RESOLVED)
FLUSH_CYCLES, 2, cycles of frontend flush after restore (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
res_valid  in  [NUM_RESOLVE]x1  branch result valid
res_id  in  [NUM_RESOLVE]xCPW  checkpoint id of the resolved branch
res_mispredict  in  [NUM_RESOLVE]x1  1 = mispredicted
checkpoint_back  in  CPW  oldest live checkpoint (age base)
validate  out  [NUM_RESOLVE]x1  to checkpointer validate
validated_id  out  [NUM_RESOLVE]xCPW  to checkpointer validated_id
recall_checkpoint  out  1  one-cycle recall strobe
recall_id  out  CPW  checkpoint being recalled
restore_en  out  1  recalled_data valid; rename/free-list load it this cycle
flush_frontend  out  1  kill fetch/decode contents
recovery_stall  out  1  stall rename/dispatch
busy  out  1  FSM not IDLE

Behaviour:
- Age of id = (id - checkpoint_back) mod NUM_CHECKPOINTS, CPW-bit unsigned wrap. Smaller age = older.
- FSM states: IDLE, RECALL, RESTORE, FLUSH. State and active_id/active_age registers are reset asynchronously.
- Reset values: state=IDLE, recall_checkpoint=0, recall_id=0, restore_en=0, flush_frontend=0, recovery_stall=0, busy=0, validate=0, validated_id=0.
- Candidate = valid lane with mispredict=1 and minimum age. On an age tie, the lowest lane wins.
- IDLE: if a candidate exists, latch active_id/active_age and go to RECALL next cycle. Otherwise stay in IDLE.
- RECALL: recall_checkpoint=1 and recall_id=active_id for exactly one cycle, then go to RESTORE.
- RESTORE: restore_en=1 for one cycle (the distributed-RAM read completes then), then go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
- FLUSH: flush_frontend=1. The counter decrements each cycle; at 0 go to IDLE.
- recall_checkpoint, recall_id, restore_en and flush_frontend are registered: they are decoded from the state register, not from the inputs.
- recovery_stall = busy, plus combinational assertion in IDLE when a candidate is present. Stall is therefore asserted in the same cycle the mispredict arrives.
- Validation path (combinational, registered-free): validate[i] = res_valid[i] & ~res_mispredict[i] & keep[i]; validated_id[i] = res_id[i].
  - keep[i] = 1 in IDLE with no candidate.
  - Otherwise keep[i] = age(res_id[i]) < reference age. The reference age is the candidate age in IDLE and active_age when busy.
  - Branches younger than or equal to the recovery point are squashed and never validated.
- Preemption: while busy, a new candidate with age < active_age replaces active_id/active_age and forces the next state to RECALL. This applies in any non-IDLE state, including RESTORE and FLUSH.
- Mispredicts with age >= active_age arriving while busy are dropped.
- Mispredict arriving in the last FLUSH cycle: if it is older, it preempts. Otherwise it is dropped.
- No back-to-back duplicate recall of the same id without preemption.
- Reset asserted mid-sequence returns to IDLE immediately and deasserts all outputs asynchronously.

Test Plan:
1. Lane0 valid, id=3, correct; back=0; idle -> validate[0]=1, validated_id[0]=3 same cycle; busy stays 0.
2. Lane1 mispredict id=5, back=2 -> stall=1 that cycle. Next cycle recall_checkpoint=1, recall_id=5. Then one cycle restore_en=1. Then flush_frontend=1 for 2 cycles. Then busy=0. Total busy 4 cycles.
3. Same cycle: lane0 mispredict id=1 and lane1 mispredict id=6, back=5 (ages 4 and 1) -> recall_id=6. Lane0 not validated.
4. During FLUSH of recovery id=4 (back=0), mispredict id=2 arrives -> next cycle state RECALL, recall_id=2. A correct branch id=1 in that same cycle is validated; a correct branch id=3 is not.
5. Wrap-around: back=6, mispredicts id=7 and id=0 together -> recall_id=7 (age 1 < 2).
6. Assert reset during RESTORE -> restore_en, busy, recovery_stall drop to 0 without waiting for a clock edge. After release the FSM is in IDLE.
